// File: rtl/rnm_ramp_sequencer.sv
// Ramp/hold stimulus sequencer for the RNM inverter: drives vin through rise/high/fall/low
// periods between VSS and VDD and counts plateau-end logic mismatches on vout.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start, vin at VSS
// RISE  | step climbs 1..NUM_STEPS, one level per clock
// HIGH  | vin at VDD for max(hold,1) clocks, vout must read low at the end
// FALL  | step drops NUM_STEPS-1..0, one level per clock
// LOW   | vin at VSS for max(hold,1) clocks, vout must read high at the end
// DONE  | single-cycle completion pulse, then back to IDLE
module rnm_ramp_sequencer #(
  parameter real VDD       = 1.8,
  parameter real VSS       = 0.0,
  parameter int  NUM_STEPS = 10,
  parameter int  HOLD_W    = 16,
  parameter int  CYC_W     = 8,
  parameter int  ERR_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [HOLD_W-1:0] hold_cycles,
  input  logic [CYC_W-1:0]  num_cycles,
  input  real               vout,
  output real               vin,
  output logic              busy,
  output logic              done,
  output logic [CYC_W-1:0]  cycle_cnt,
  output logic [ERR_W-1:0]  err_cnt
);

  localparam int STEP_W = $clog2(NUM_STEPS + 1);
  localparam logic [STEP_W-1:0] STEP_MAX = STEP_W'(NUM_STEPS);
  localparam real VTH = (VSS + VDD) / 2.0;

  typedef enum logic [2:0] {
    S_IDLE, S_RISE, S_HIGH, S_FALL, S_LOW, S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [STEP_W-1:0]  step_q, step_d;
  logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic [HOLD_W-1:0]  hold_lat_q, hold_lat_d;
  logic [CYC_W-1:0]   num_lat_q, num_lat_d;
  logic [CYC_W-1:0]   cycle_cnt_q, cycle_cnt_d;
  logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  real                vin_q, vin_d;

  logic [HOLD_W-1:0]  hold_load;
  logic [ERR_W-1:0]   err_sat;
  logic [CYC_W-1:0]   cyc_inc;
  logic               run_active;

  // Rails are returned as the parameter values themselves so HIGH/LOW are exact.
  function automatic real level(input logic [STEP_W-1:0] s);
    if (s == STEP_MAX) return VDD;
    if (s == '0) return VSS;
    return VSS + (real'(int'(s)) * (VDD - VSS)) / real'(NUM_STEPS);
  endfunction

  // Down-counter preload: a hold of 0 behaves as 1, so terminal count is hold-1.
  assign hold_load  = (hold_lat_q == '0) ? '0 : hold_lat_q - HOLD_W'(1);
  assign err_sat    = (err_cnt_q == '1) ? err_cnt_q : err_cnt_q + ERR_W'(1);
  assign cyc_inc    = cycle_cnt_q + CYC_W'(1);
  assign run_active = (state_q == S_RISE) || (state_q == S_HIGH) ||
                      (state_q == S_FALL) || (state_q == S_LOW);

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    hold_cnt_d  = hold_cnt_q;
    hold_lat_d  = hold_lat_q;
    num_lat_d   = num_lat_q;
    cycle_cnt_d = cycle_cnt_q;
    err_cnt_d   = err_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          hold_lat_d  = hold_cycles;
          num_lat_d   = num_cycles;
          cycle_cnt_d = '0;
          err_cnt_d   = '0;
          if (num_cycles == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RISE;
            step_d  = STEP_W'(1);
          end
        end
      end
      S_RISE: begin
        if (step_q == STEP_MAX) begin
          state_d    = S_HIGH;
          hold_cnt_d = hold_load;
        end else begin
          step_d = step_q + STEP_W'(1);
        end
      end
      S_HIGH: begin
        if (hold_cnt_q == '0) begin
          if (vout >= VTH) err_cnt_d = err_sat;
          state_d = S_FALL;
          step_d  = step_q - STEP_W'(1);
        end else begin
          hold_cnt_d = hold_cnt_q - HOLD_W'(1);
        end
      end
      S_FALL: begin
        if (step_q == '0) begin
          state_d    = S_LOW;
          hold_cnt_d = hold_load;
        end else begin
          step_d = step_q - STEP_W'(1);
        end
      end
      S_LOW: begin
        if (hold_cnt_q == '0) begin
          if (vout < VTH) err_cnt_d = err_sat;
          cycle_cnt_d = cyc_inc;
          if (cyc_inc == num_lat_q) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RISE;
            step_d  = STEP_W'(1);
          end
        end else begin
          hold_cnt_d = hold_cnt_q - HOLD_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Abort discards whatever the current state would have counted this cycle.
    if (abort && run_active) begin
      state_d     = S_IDLE;
      step_d      = '0;
      hold_cnt_d  = '0;
      cycle_cnt_d = cycle_cnt_q;
      err_cnt_d   = err_cnt_q;
    end

    busy_d = (state_d == S_RISE) || (state_d == S_HIGH) ||
             (state_d == S_FALL) || (state_d == S_LOW);
    done_d = (state_d == S_DONE);
    vin_d  = level(step_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      step_q      <= '0;
      hold_cnt_q  <= '0;
      hold_lat_q  <= '0;
      num_lat_q   <= '0;
      cycle_cnt_q <= '0;
      err_cnt_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      vin_q       <= VSS;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      hold_cnt_q  <= hold_cnt_d;
      hold_lat_q  <= hold_lat_d;
      num_lat_q   <= num_lat_d;
      cycle_cnt_q <= cycle_cnt_d;
      err_cnt_q   <= err_cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      vin_q       <= vin_d;
    end
  end

  assign vin       = vin_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign cycle_cnt = cycle_cnt_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_rnm_ramp_sequencer.sv
// Bench for rnm_ramp_sequencer: table vectors, abort/reset corner sequences and random runs
// checked against a period-position model of the expected vin trace and mismatch totals.
module tb_rnm_ramp_sequencer;

  localparam real VDD_M = 1.8;
  localparam real VSS_M = 0.0;
  localparam real VTH_M = (VSS_M + VDD_M) / 2.0;
  localparam int  NS    = 10;

  logic        clk = 1'b0;
  logic        rst, start, abort;
  logic [15:0] hold_cycles;
  logic [7:0]  num_cycles;
  real         vout, vin;
  logic        busy, done;
  logic [7:0]  cycle_cnt, err_cnt;
  int          vmode;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  // vout modes: 0 ideal inverter, 1 stuck high, 2 stuck low, 3 follower, 4 exactly at threshold
  always_comb begin
    case (vmode)
      0:       vout = VDD_M - vin;
      1:       vout = VDD_M;
      2:       vout = VSS_M;
      3:       vout = vin;
      default: vout = VTH_M;
    endcase
  end

  rnm_ramp_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .hold_cycles(hold_cycles), .num_cycles(num_cycles), .vout(vout),
    .vin(vin), .busy(busy), .done(done), .cycle_cnt(cycle_cnt), .err_cnt(err_cnt)
  );

  typedef struct {
    int    h;
    int    n;
    int    mode;
    int    len;
    int    err;
    int    cyc;
    string nm;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_int(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_real(input string nm, input real act, input real exp, input bit exact);
    real d;
    checks++;
    d = act - exp;
    if (exact ? (act != exp) : (d > 1e-9 || d < -1e-9)) begin
      errors++;
      $display("FAIL %s: got %f expected %f", nm, act, exp);
    end
  endtask

  // Expected vin k clocks after start was accepted, from the position inside the period.
  function automatic real exp_vin(input int k, input int h, output bit rail);
    int hh, p, lvl;
    hh = (h < 1) ? 1 : h;
    p  = k % (2 * (NS + hh));
    if (p < NS)               lvl = p + 1;
    else if (p < NS + hh)     lvl = NS;
    else if (p < 2 * NS + hh) lvl = NS - 1 - (p - NS - hh);
    else                      lvl = 0;
    rail = (lvl == 0) || (lvl == NS);
    if (lvl == NS) return VDD_M;
    if (lvl == 0)  return VSS_M;
    return VSS_M + real'(lvl) * (VDD_M - VSS_M) / real'(NS);
  endfunction

  function automatic int errs_per(input int m);
    case (m)
      0:       return 0;
      3:       return 2;
      default: return 1;
    endcase
  endfunction

  task automatic run_check(input int h, input int n, input int m, input int len,
                           input int err, input int cyc, input string nm);
    bit  rail;
    real e;
    vmode       = m;
    hold_cycles = 16'(h);
    num_cycles  = 8'(n);
    start       = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < len; k++) begin
      e = exp_vin(k, h, rail);
      chk_int({nm, ".busy"}, longint'(busy), 1);
      chk_real({nm, ".vin"}, vin, e, rail);
      start       = 1'($urandom_range(0, 1));
      hold_cycles = 16'($urandom);
      num_cycles  = 8'($urandom);
      tick();
    end
    chk_int({nm, ".done"}, longint'(done), 1);
    chk_int({nm, ".busy_end"}, longint'(busy), 0);
    chk_real({nm, ".vin_end"}, vin, VSS_M, 1'b1);
    chk_int({nm, ".cycle_cnt"}, longint'(cycle_cnt), cyc);
    chk_int({nm, ".err_cnt"}, longint'(err_cnt), err);
    start      = 1'b1;
    num_cycles = 8'd1;
    tick();
    start = 1'b0;
    chk_int({nm, ".done_once"}, longint'(done), 0);
    chk_int({nm, ".no_restart"}, longint'(busy), 0);
    chk_int({nm, ".cnt_hold"}, longint'(cycle_cnt), cyc);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int h, n, m, len, err;
    vecs[0] = '{h: 4, n: 2,   mode: 0, len: 56,   err: 0,   cyc: 2,   nm: "ideal_h4_n2"};
    vecs[1] = '{h: 4, n: 2,   mode: 1, len: 56,   err: 2,   cyc: 2,   nm: "stuck_hi"};
    vecs[2] = '{h: 0, n: 1,   mode: 0, len: 22,   err: 0,   cyc: 1,   nm: "hold0"};
    vecs[3] = '{h: 3, n: 0,   mode: 0, len: 0,    err: 0,   cyc: 0,   nm: "n0"};
    vecs[4] = '{h: 1, n: 3,   mode: 3, len: 66,   err: 6,   cyc: 3,   nm: "follower"};
    vecs[5] = '{h: 2, n: 3,   mode: 4, len: 72,   err: 3,   cyc: 3,   nm: "at_vth"};
    vecs[6] = '{h: 3, n: 2,   mode: 2, len: 52,   err: 2,   cyc: 2,   nm: "stuck_lo"};
    vecs[7] = '{h: 0, n: 200, mode: 3, len: 4400, err: 255, cyc: 200, nm: "err_sat"};

    rst = 1'b1; start = 1'b0; abort = 1'b0;
    hold_cycles = '0; num_cycles = '0; vmode = 0;
    tick();
    tick();
    chk_real("rst.vin", vin, VSS_M, 1'b1);
    chk_int("rst.busy", longint'(busy), 0);
    chk_int("rst.done", longint'(done), 0);
    chk_int("rst.cycle_cnt", longint'(cycle_cnt), 0);
    chk_int("rst.err_cnt", longint'(err_cnt), 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 8; i++)
      run_check(vecs[i].h, vecs[i].n, vecs[i].mode, vecs[i].len, vecs[i].err,
                vecs[i].cyc, vecs[i].nm);

    // Abort on the 5th FALL cycle of the second period, counters must survive.
    vmode = 1; hold_cycles = 16'd4; num_cycles = 8'd2; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 46; k++) begin
      if (k == 2)  chk_real("ab.rise3", vin, 0.54, 1'b0);
      if (k == 10) chk_real("ab.high", vin, VDD_M, 1'b1);
      tick();
    end
    chk_real("ab.fall5", vin, 0.9, 1'b0);
    chk_int("ab.busy_pre", longint'(busy), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_int("ab.busy", longint'(busy), 0);
    chk_int("ab.done", longint'(done), 0);
    chk_real("ab.vin", vin, VSS_M, 1'b1);
    chk_int("ab.cycle_cnt", longint'(cycle_cnt), 1);
    chk_int("ab.err_cnt", longint'(err_cnt), 2);
    tick();
    chk_int("ab.no_done", longint'(done), 0);
    run_check(4, 1, 0, 28, 0, 1, "after_abort");

    // Reset during HIGH of the second period with start held high.
    vmode = 1; hold_cycles = 16'd4; num_cycles = 8'd3; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 39; k++) tick();
    chk_int("rr.cyc_pre", longint'(cycle_cnt), 1);
    chk_int("rr.err_pre", longint'(err_cnt), 1);
    rst = 1'b1; start = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0;
    chk_real("rr.vin", vin, VSS_M, 1'b1);
    chk_int("rr.busy", longint'(busy), 0);
    chk_int("rr.done", longint'(done), 0);
    chk_int("rr.cycle_cnt", longint'(cycle_cnt), 0);
    chk_int("rr.err_cnt", longint'(err_cnt), 0);
    tick();
    chk_int("rr.no_run", longint'(busy), 0);
    run_check(2, 2, 0, 48, 0, 2, "after_rst");

    for (int r = 0; r < 25; r++) begin
      h   = $urandom_range(0, 6);
      n   = $urandom_range(0, 4);
      m   = $urandom_range(0, 4);
      len = n * 2 * (NS + ((h < 1) ? 1 : h));
      err = n * errs_per(m);
      if (err > 255) err = 255;
      run_check(h, n, m, len, err, n, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
